// File: rtl/rpn_stack_sequencer.sv
// rtl/rpn_stack_sequencer.sv - stack-based operand sequencer for the RPN calculator ALU
// Optional peek port for display scrolling is enabled by defining RPN_PEEK_EN.
module rpn_stack_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_req,
  input  logic                       exec_req,
  input  logic                       clear_req,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [2:0]                 opcode_in,
  input  logic [WIDTH-1:0]           alu_res,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [2:0]                 alu_op,
  output logic [WIDTH-1:0]           top_out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
`ifdef RPN_PEEK_EN
  input  logic [$clog2(DEPTH)-1:0]   peek_sel,
  output logic [WIDTH-1:0]           peek_data,
`endif
  output logic                       busy,
  output logic                       err_overflow,
  output logic                       err_underflow,
  output logic [2:0]                 status
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ALU_LAT+1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PUSH       = 3'd1,
    S_EXEC_SETUP = 3'd2,
    S_EXEC_WAIT  = 3'd3,
    S_WRITEBACK  = 3'd4,
    S_ERROR      = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic [WIDTH-1:0]  stack_q [DEPTH];
  logic [WIDTH-1:0]  stack_d [DEPTH];
  logic [WIDTH-1:0]  push_q, push_d;
  logic [WIDTH-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_ov_q, err_ov_d, err_un_q, err_un_d;
  logic [AW-1:0]     top_idx, nos_idx, wr_idx;

  assign top_idx = AW'(depth_q - DW'(1));
  assign nos_idx = AW'(depth_q - DW'(2));
  assign wr_idx  = AW'(depth_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      depth_q  <= '0;
      push_q   <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      cnt_q    <= '0;
      err_ov_q <= 1'b0;
      err_un_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      push_q   <= push_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      cnt_q    <= cnt_d;
      err_ov_q <= err_ov_d;
      err_un_q <= err_un_d;
      stack_q  <= stack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    stack_d  = stack_q;
    push_d   = push_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    cnt_d    = cnt_q;
    err_ov_d = err_ov_q;
    err_un_d = err_un_q;
    case (state_q)
      S_IDLE: begin
        // clear beats exec beats push; losers are simply dropped
        if (clear_req) begin
          depth_d  = '0;
          err_ov_d = 1'b0;
          err_un_d = 1'b0;
          for (int i = 0; i < DEPTH; i++) stack_d[i] = '0;
        end else if (exec_req) begin
          if (depth_q < DW'(2)) begin
            state_d  = S_ERROR;
            err_un_d = 1'b1;
          end else begin
            alu_op_d = opcode_in;
            state_d  = S_EXEC_SETUP;
          end
        end else if (push_req) begin
          if (depth_q == DW'(DEPTH)) begin
            state_d  = S_ERROR;
            err_ov_d = 1'b1;
          end else begin
            push_d  = data_in;
            state_d = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        stack_d[wr_idx] = push_q;
        depth_d         = depth_q + DW'(1);
        state_d         = S_IDLE;
      end
      S_EXEC_SETUP: begin
        alu_a_d = stack_q[nos_idx];
        alu_b_d = stack_q[top_idx];
        cnt_d   = CW'(ALU_LAT);
        state_d = S_EXEC_WAIT;
      end
      S_EXEC_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        stack_d[nos_idx] = alu_res;
        stack_d[top_idx] = '0;
        depth_d          = depth_q - DW'(1);
        state_d          = S_IDLE;
      end
      S_ERROR: begin
        if (clear_req) begin
          depth_d  = '0;
          err_ov_d = 1'b0;
          err_un_d = 1'b0;
          for (int i = 0; i < DEPTH; i++) stack_d[i] = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign depth         = depth_q;
  assign top_out       = (depth_q != '0) ? stack_q[top_idx] : '0;
  assign busy          = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign err_overflow  = err_ov_q;
  assign err_underflow = err_un_q;
  assign status        = state_q;

`ifdef RPN_PEEK_EN
  // peek_sel counts down from the top of stack
  assign peek_data = (DW'(peek_sel) < depth_q)
                   ? stack_q[AW'(depth_q - DW'(1) - DW'(peek_sel))] : '0;
`endif

endmodule

// File: doc/rpn_stack_sequencer.md
Name: rpn_stack_sequencer

Overview:
- Controller for the reverse-polish calculator datapath.
- Owns a DEPTH-entry operand stack and sequences the shared ALU: push operands, pop two, present them with a captured opcode, wait for the ALU, write the result back.
- Sits between the debounced button/switch inputs and the ALU/display mux.
- Replaces fixed OpA/OpB/OpCode load sequencing with stack-based chained evaluation.

Parameters:
- WIDTH, 16, operand/result width.
- DEPTH, 4, stack entries (>=2).
- ALU_LAT, 1, cycles spent in EXEC_WAIT before writeback (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- push_req  in  1  one-cycle debounced pulse; push data_in.
- exec_req  in  1  one-cycle debounced pulse; execute opcode_in on top two entries.
- clear_req  in  1  one-cycle pulse; empty stack, clear errors.
- data_in  in  WIDTH  operand from switches.
- opcode_in  in  3  operation code; opaque to this block.
- alu_res  in  WIDTH  ALU result, valid ALU_LAT cycles after operands are presented.
- alu_a  out  WIDTH  registered ALU operand A (second from top).
- alu_b  out  WIDTH  registered ALU operand B (top).
- alu_op  out  3  registered opcode.
- top_out  out  WIDTH  stack top to display; 0 when empty.
- depth  out  $clog2(DEPTH+1)  entries in use.
- busy  out  1  high in every state except IDLE and ERROR.
- err_overflow  out  1  sticky; push attempted at depth==DEPTH.
- err_underflow  out  1  sticky; exec attempted at depth<2.
- status  out  3  state code: IDLE=0, PUSH=1, EXEC_SETUP=2, EXEC_WAIT=3, WRITEBACK=4, ERROR=7.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE, depth=0, all stack entries=0, wait counter=0.
  - alu_a=0, alu_b=0, alu_op=0, err flags=0, busy=0, status=0, top_out=0.
- IDLE request priority: clear_req > exec_req > push_req. Lower-priority simultaneous requests are dropped.
- IDLE + clear_req: depth<=0, entries zeroed, errors cleared; stay in IDLE.
- IDLE + push_req:
  - If depth==DEPTH: go to ERROR, set err_overflow; stack unchanged.
  - Otherwise: latch data_in at the request edge, go to PUSH.
- PUSH: next edge writes stack[depth]=latched value, depth+1, back to IDLE. New depth is visible 2 edges after the request.
- IDLE + exec_req:
  - If depth<2: go to ERROR, set err_underflow; stack unchanged.
  - Otherwise: alu_op<=opcode_in at the request edge, go to EXEC_SETUP.
- EXEC_SETUP: alu_a<=stack[depth-2], alu_b<=stack[depth-1]; load wait counter with ALU_LAT; go to EXEC_WAIT.
- EXEC_WAIT: decrement the counter each cycle; go to WRITEBACK when it reaches 0.
- WRITEBACK: stack[depth-2]<=alu_res, depth-1, vacated entry zeroed; go to IDLE.
  - Exec total: request to IDLE with updated depth = ALU_LAT+3 edges.
  - alu_a, alu_b and alu_op hold their last values until the next EXEC_SETUP.
- push_req and exec_req are ignored while busy=1. clear_req is also ignored while busy; no queuing.
- ERROR:
  - push_req and exec_req are ignored.
  - Only clear_req exits: to IDLE with stack emptied and both flags cleared.
  - Flags remain set in ERROR.
- top_out is combinational from registers: stack[depth-1] when depth>0, else 0.
- Arithmetic is the ALU's concern: alu_res is written back as-is, with no width extension or saturation here.

Optional Feature:
- Macro RPN_PEEK_EN.
- When defined: adds input peek_sel [$clog2(DEPTH)-1:0] and output peek_data [WIDTH-1:0].
  - peek_data = stack[depth-1-peek_sel], combinational.
  - peek_data = 0 when peek_sel>=depth.
  - Used for scrolling the stack on the display.
- When undefined: ports absent, no additional logic.

Test Plan:
- Reset mid-EXEC_WAIT (ALU_LAT=3) with depth=3 -> immediately depth=0, status=0, top_out=0, alu_a/alu_b/alu_op=0.
- Push 0x0005, push 0x0003, exec op=0 (bench ALU add) -> alu_a=5, alu_b=3 after EXEC_SETUP; after WRITEBACK depth=1, top_out=0x0008; busy high exactly ALU_LAT+2 cycles.
- Push 4 values (DEPTH=4), then push again -> status=7, err_overflow=1, depth=4, top_out=4th value; exec_req then ignored; clear_req -> depth=0, flags=0, status=0.
- Push one value, exec -> err_underflow=1, status=7, depth unchanged at 1.
- push_req and exec_req in the same cycle with depth=2 -> exec wins, depth ends 1, no push. Pulse push_req during EXEC_WAIT -> ignored, depth still 1 after WRITEBACK.
- RPN_PEEK_EN defined, stack [0x0001,0x0002,0x0003]: peek_sel=0 -> 0x0003; peek_sel=2 -> 0x0001; peek_sel=3 -> 0x0000.
